// File: rtl/otter_iobus_responder.sv
// Memory-mapped switch/LED/seven-segment/timer peripheral for the OTTER CPU I/O bus.
// Reads are combinational; writes are applied on the strobed edge; never stalls the CPU.
`timescale 1ns/1ps
module otter_iobus_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
  parameter int          SW_WIDTH  = 16
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [31:0]         IOBUS_ADDR,
  input  logic [31:0]         IOBUS_OUT,
  input  logic                IOBUS_WR,
  output logic [31:0]         IOBUS_IN,
  input  logic [SW_WIDTH-1:0] SWITCHES,
  output logic [SW_WIDTH-1:0] LEDS,
  output logic [SW_WIDTH-1:0] SSEG,
  output logic                TMR_IRQ
);

  localparam logic [31:0] ADDR_SW     = BASE_ADDR + 32'h00;
  localparam logic [31:0] ADDR_LEDS   = BASE_ADDR + 32'h20;
  localparam logic [31:0] ADDR_SSEG   = BASE_ADDR + 32'h40;
  localparam logic [31:0] ADDR_CTRL   = BASE_ADDR + 32'h60;
  localparam logic [31:0] ADDR_LOAD   = BASE_ADDR + 32'h64;
  localparam logic [31:0] ADDR_COUNT  = BASE_ADDR + 32'h68;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h6C;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    HALTED  = 2'd2
  } tmr_state_t;

  tmr_state_t          state;
  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;
  logic [2:0]          ctrl;
  logic [31:0]         load_reg;
  logic [31:0]         count;
  logic                exp_flag;

  logic ctrl_en, ctrl_auto, ctrl_ie;
  logic wr_leds, wr_sseg, wr_ctrl, wr_load, wr_clear;
  logic expire;

  assign ctrl_en   = ctrl[0];
  assign ctrl_auto = ctrl[1];
  assign ctrl_ie   = ctrl[2];

  assign wr_leds  = IOBUS_WR && (IOBUS_ADDR == ADDR_LEDS);
  assign wr_sseg  = IOBUS_WR && (IOBUS_ADDR == ADDR_SSEG);
  assign wr_ctrl  = IOBUS_WR && (IOBUS_ADDR == ADDR_CTRL);
  assign wr_load  = IOBUS_WR && (IOBUS_ADDR == ADDR_LOAD);
  assign wr_clear = IOBUS_WR && (IOBUS_ADDR == ADDR_STATUS) && IOBUS_OUT[0];

  // A load write pre-empts both the decrement and the expiry on that edge.
  assign expire = ctrl_en && (state == RUNNING) && !wr_load && (count == 32'd1);

  assign TMR_IRQ = exp_flag & ctrl_ie;

  always_comb begin
    IOBUS_IN = 32'd0;
    case (IOBUS_ADDR)
      ADDR_SW:     IOBUS_IN = 32'(sw_sync);
      ADDR_LEDS:   IOBUS_IN = 32'(LEDS);
      ADDR_SSEG:   IOBUS_IN = 32'(SSEG);
      ADDR_CTRL:   IOBUS_IN = {29'd0, ctrl};
      ADDR_LOAD:   IOBUS_IN = load_reg;
      ADDR_COUNT:  IOBUS_IN = count;
      ADDR_STATUS: IOBUS_IN = {31'd0, exp_flag};
      default:     IOBUS_IN = 32'd0;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      sw_meta <= '0;
      sw_sync <= '0;
      LEDS    <= '0;
      SSEG    <= '0;
    end else begin
      sw_meta <= SWITCHES;
      sw_sync <= sw_meta;
      if (wr_leds) LEDS <= IOBUS_OUT[SW_WIDTH-1:0];
      if (wr_sseg) SSEG <= IOBUS_OUT[SW_WIDTH-1:0];
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      ctrl     <= 3'd0;
      load_reg <= 32'd0;
      count    <= 32'd0;
      exp_flag <= 1'b0;
      state    <= STOPPED;
    end else begin
      if (wr_ctrl) ctrl <= IOBUS_OUT[2:0];
      if (wr_load) load_reg <= IOBUS_OUT;

      // Set beats clear when both land on the same edge.
      if (expire)        exp_flag <= 1'b1;
      else if (wr_clear) exp_flag <= 1'b0;

      if (!ctrl_en) begin
        state <= STOPPED;
        if (wr_load) count <= IOBUS_OUT;
      end else if (wr_load) begin
        count <= IOBUS_OUT;
        if (IOBUS_OUT != 32'd0) state <= RUNNING;
        else if (state != STOPPED) state <= HALTED;
      end else begin
        case (state)
          STOPPED: begin
            if (count != 32'd0) state <= RUNNING;
          end
          RUNNING: begin
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else if (count == 32'd1 && ctrl_auto && load_reg != 32'd0) begin
              count <= load_reg;
            end else begin
              count <= 32'd0;
              state <= HALTED;
            end
          end
          HALTED:  state <= HALTED;
          default: state <= STOPPED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_otter_iobus_responder.sv
// Randomized and directed bench for otter_iobus_responder against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_otter_iobus_responder;

  localparam logic [31:0] B = 32'h1100_0000;
  localparam int STOP = 0;
  localparam int RUN  = 1;
  localparam int HALT = 2;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] IOBUS_ADDR = 32'd0;
  logic [31:0] IOBUS_OUT = 32'd0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic [15:0] SWITCHES = 16'hFFFF;
  logic [15:0] LEDS;
  logic [15:0] SSEG;
  logic        TMR_IRQ;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_leds, m_sseg, m_s1, m_s2;
  logic [2:0]  m_ctrl;
  logic [31:0] m_load, m_count;
  logic        m_exp;
  int          m_mode;

  otter_iobus_responder #(.BASE_ADDR(32'h1100_0000), .SW_WIDTH(16)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .SWITCHES(SWITCHES), .LEDS(LEDS),
    .SSEG(SSEG), .TMR_IRQ(TMR_IRQ)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic m_reset();
    m_leds = 0; m_sseg = 0; m_s1 = 0; m_s2 = 0; m_ctrl = 0;
    m_load = 0; m_count = 0; m_exp = 0; m_mode = STOP;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == B)              return {16'd0, m_s2};
    if (a == B + 32'h20)     return {16'd0, m_leds};
    if (a == B + 32'h40)     return {16'd0, m_sseg};
    if (a == B + 32'h60)     return {29'd0, m_ctrl};
    if (a == B + 32'h64)     return m_load;
    if (a == B + 32'h68)     return m_count;
    if (a == B + 32'h6C)     return {31'd0, m_exp};
    return 32'd0;
  endfunction

  // One rising edge of the peripheral, from the register-level rules.
  task automatic m_edge(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [15:0] sw);
    bit          wl;
    bit          en;
    bit          fired;
    logic [31:0] nc;
    int          nm;
    wl = w && (a == B + 32'h64);
    en = m_ctrl[0];
    fired = 0;
    nc = m_count;
    nm = m_mode;
    if (wl) begin
      nc = d;
      if (!en) nm = STOP;
      else if (d != 0) nm = RUN;
      else if (m_mode != STOP) nm = HALT;
    end else if (!en) begin
      nm = STOP;
    end else if (m_mode == STOP) begin
      if (m_count != 0) nm = RUN;
    end else if (m_mode == RUN) begin
      if (m_count > 1) nc = m_count - 1;
      else begin
        fired = (m_count == 1);
        if (fired && m_ctrl[1] && m_load != 0) nc = m_load;
        else begin nc = 0; nm = HALT; end
      end
    end
    if (fired) m_exp = 1;
    else if (w && a == B + 32'h6C && d[0]) m_exp = 0;
    if (w && a == B + 32'h20) m_leds = d[15:0];
    if (w && a == B + 32'h40) m_sseg = d[15:0];
    if (w && a == B + 32'h60) m_ctrl = d[2:0];
    if (wl) m_load = d;
    m_s2 = m_s1;
    m_s1 = sw;
    m_count = nc;
    m_mode = nm;
  endtask

  // Drive one bus cycle, check the read, clock it, then check registered outputs.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w);
    IOBUS_ADDR = a; IOBUS_OUT = d; IOBUS_WR = w;
    #1;
    chk("read", IOBUS_IN, m_read(a));
    @(posedge CLOCK);
    m_edge(a, d, w, SWITCHES);
    #1;
    IOBUS_WR = 1'b0;
    chk("leds", {16'd0, LEDS}, {16'd0, m_leds});
    chk("sseg", {16'd0, SSEG}, {16'd0, m_sseg});
    chk("irq", {31'd0, TMR_IRQ}, {31'd0, m_exp & m_ctrl[2]});
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] expv);
    IOBUS_ADDR = a; IOBUS_WR = 1'b0;
    #1;
    chk(tag, IOBUS_IN, expv);
  endtask

  logic [31:0] addrs [11];

  initial begin
    addrs = '{B, B + 32'h20, B + 32'h40, B + 32'h60, B + 32'h64, B + 32'h68,
              B + 32'h6C, B + 32'h10, B + 32'h70, B + 32'h04, 32'h0000_0020};
    m_reset();

    // Reset state
    #2;
    chk("rst_leds", {16'd0, LEDS}, 32'd0);
    chk("rst_sseg", {16'd0, SSEG}, 32'd0);
    chk("rst_irq", {31'd0, TMR_IRQ}, 32'd0);
    rd("rst_sw", B, 32'd0);
    rd("rst_count", B + 32'h68, 32'd0);
    @(posedge CLOCK);
    #1;
    RESET = 1'b1;
    SWITCHES = 16'h0000;
    cyc(B, 0, 0);
    cyc(B, 0, 0);

    // LED write and zero-extended readback
    cyc(B + 32'h20, 32'hDEAD_BEEF, 1);
    chk("leds_beef", {16'd0, LEDS}, 32'h0000_BEEF);
    rd("leds_rd", B + 32'h20, 32'h0000_BEEF);
    cyc(B + 32'h40, 32'h1234_A5A5, 1);
    chk("sseg_a5", {16'd0, SSEG}, 32'h0000_A5A5);

    // Switch synchronizer latency
    SWITCHES = 16'h0002;
    rd("sw_edge0", B, 32'd0);
    cyc(B, 0, 0);
    rd("sw_edge1", B, 32'd0);
    cyc(B, 0, 0);
    rd("sw_edge2", B, 32'h0000_0002);

    // One-shot countdown
    cyc(B + 32'h60, 32'h5, 1);
    cyc(B + 32'h64, 32'd3, 1);
    rd("os_c3", B + 32'h68, 32'd3);
    cyc(B, 0, 0);
    rd("os_c2", B + 32'h68, 32'd2);
    cyc(B, 0, 0);
    rd("os_c1", B + 32'h68, 32'd1);
    rd("os_exp0", B + 32'h6C, 32'd0);
    cyc(B, 0, 0);
    rd("os_c0", B + 32'h68, 32'd0);
    rd("os_exp1", B + 32'h6C, 32'd1);
    chk("os_irq", {31'd0, TMR_IRQ}, 32'd1);
    cyc(B, 0, 0);
    cyc(B, 0, 0);
    rd("os_halt", B + 32'h68, 32'd0);
    cyc(B + 32'h6C, 32'h1, 1);
    chk("os_clr_irq", {31'd0, TMR_IRQ}, 32'd0);

    // Auto-reload, W1C on and off the expiry edge
    cyc(B + 32'h60, 32'h7, 1);
    cyc(B + 32'h64, 32'd2, 1);
    rd("ar_c2a", B + 32'h68, 32'd2);
    cyc(B, 0, 0);
    rd("ar_c1a", B + 32'h68, 32'd1);
    cyc(B + 32'h6C, 32'h1, 1);
    rd("ar_c2b", B + 32'h68, 32'd2);
    rd("ar_setwins", B + 32'h6C, 32'd1);
    cyc(B + 32'h6C, 32'h1, 1);
    rd("ar_c1b", B + 32'h68, 32'd1);
    rd("ar_cleared", B + 32'h6C, 32'd0);
    chk("ar_irq0", {31'd0, TMR_IRQ}, 32'd0);
    cyc(B + 32'h6C, 32'h0, 1);
    rd("ar_c2c", B + 32'h68, 32'd2);
    chk("ar_irq1", {31'd0, TMR_IRQ}, 32'd1);
    cyc(B + 32'h60, 32'h0, 1);

    // Unmapped and read-only addresses
    rd("unmapped_rd", B + 32'h10, 32'd0);
    cyc(B + 32'h70, 32'hFFFF_FFFF, 1);
    cyc(B, 32'hFFFF_FFFF, 1);
    cyc(B + 32'h68, 32'hFFFF_FFFF, 1);
    chk("unmapped_leds", {16'd0, LEDS}, 32'h0000_BEEF);
    rd("unmapped_ctrl", B + 32'h60, 32'd0);
    rd("unmapped_load", B + 32'h64, 32'd2);
    rd("ro_sw", B, 32'h0000_0002);
    rd("ro_count", B + 32'h68, m_count);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic        w;
      a = addrs[$urandom_range(0, 10)];
      d = $urandom;
      if (a == B + 32'h64) d = $urandom_range(0, 5);
      if (a == B + 32'h60 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      w = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) SWITCHES = 16'($urandom);
      cyc(a, d, w);
      rd("rnd_count", B + 32'h68, m_count);
      rd("rnd_status", B + 32'h6C, {31'd0, m_exp});
    end

    // Reset mid-count
    cyc(B + 32'h20, 32'h0000_00FF, 1);
    cyc(B + 32'h6C, 32'h1, 1);
    cyc(B + 32'h60, 32'h5, 1);
    cyc(B + 32'h64, 32'd9, 1);
    for (int i = 0; i < 4; i++) cyc(B, 0, 0);
    rd("mid_c5", B + 32'h68, 32'd5);
    #1;
    RESET = 1'b0;
    #1;
    chk("ar_leds", {16'd0, LEDS}, 32'd0);
    chk("ar_sseg", {16'd0, SSEG}, 32'd0);
    chk("ar_irq", {31'd0, TMR_IRQ}, 32'd0);
    rd("ar_count", B + 32'h68, 32'd0);
    rd("ar_sw", B, 32'd0);
    m_reset();
    @(posedge CLOCK);
    #1;
    RESET = 1'b1;
    cyc(B, 0, 0);
    rd("post_count", B + 32'h68, 32'd0);
    cyc(B + 32'h60, 32'h1, 1);
    cyc(B, 0, 0);
    cyc(B, 0, 0);
    rd("post_stopped", B + 32'h68, 32'd0);
    cyc(B + 32'h64, 32'd2, 1);
    rd("post_run_c2", B + 32'h68, 32'd2);
    cyc(B, 0, 0);
    rd("post_run_c1", B + 32'h68, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/otter_iobus_responder.md
OTTER_IOBUS_RESPONDER -- requirements
Module: otter_iobus_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1100_0000, the base of the peripheral address window.
REQ-002 SHALL have parameter SW_WIDTH, default 16, the width of SWITCHES, LEDS and SSEG.
REQ-003 SHALL have port CLOCK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port IOBUS_ADDR  input  32  byte address from the CPU.
REQ-006 SHALL have port IOBUS_OUT  input  32  write data from the CPU.
REQ-007 SHALL have port IOBUS_WR  input  1  write strobe from the CPU, one cycle per store.
REQ-008 SHALL have port IOBUS_IN  output  32  read data to the CPU.
REQ-009 SHALL have port SWITCHES  input  SW_WIDTH  asynchronous board switches.
REQ-010 SHALL have port LEDS  output  SW_WIDTH  LED register.
REQ-011 SHALL have port SSEG  output  SW_WIDTH  seven-segment data register.
REQ-012 SHALL have port TMR_IRQ  output  1  level timer interrupt to the CPU.

Function
REQ-013 SHALL use this address map, as offsets from BASE_ADDR: 0x00 SW (RO); 0x20 LEDS (RW); 0x40 SSEG (RW); 0x60 TMR_CTRL (RW); 0x64 TMR_LOAD (RW); 0x68 TMR_COUNT (RO); 0x6C TMR_STATUS (R/W1C).
REQ-014 SHALL decode the full 32-bit address; any non-matching address reads 0, and writes to it are ignored.
REQ-015 SHALL drive IOBUS_IN combinationally from IOBUS_ADDR in the same cycle, zero-extending registers narrower than 32 bits.
REQ-016 SHALL apply a write on the rising edge where IOBUS_WR=1, using IOBUS_OUT[SW_WIDTH-1:0] for LEDS and SSEG and IOBUS_OUT[2:0] for TMR_CTRL.
REQ-017 SHALL ignore writes to SW and TMR_COUNT.
REQ-018 SHALL pass SWITCHES through a 2-flop synchronizer, so the SW read reflects a switch change 2 edges later.
REQ-019 SHALL define TMR_CTRL as bit0 EN, bit1 AUTO (auto-reload) and bit2 IE (interrupt enable).
REQ-020 SHALL, on a write to TMR_LOAD, load both the 32-bit load register and TMR_COUNT with IOBUS_OUT at that edge.
REQ-021 SHALL give a TMR_LOAD write priority over a decrement on the same edge.
REQ-022 SHALL implement a timer FSM with states STOPPED, RUNNING and HALTED.
REQ-023 SHALL go from STOPPED to RUNNING when EN=1 and COUNT!=0.
REQ-024 SHALL decrement COUNT by 1 per clock while RUNNING.
REQ-025 SHALL go from any state to STOPPED when EN=0, with COUNT held.
REQ-026 SHALL treat the expiry edge as the RUNNING edge where COUNT==1; at that edge it sets the EXP flag (TMR_STATUS bit0).
REQ-027 SHALL, at expiry with AUTO=1, load COUNT from the load register and stay RUNNING; if the load register is 0, it goes to HALTED with COUNT=0.
REQ-028 SHALL, at expiry with AUTO=0, set COUNT to 0 and go to HALTED.
REQ-029 SHALL leave HALTED only on a TMR_LOAD write with a nonzero value and EN=1 (to RUNNING) or on EN cleared (to STOPPED).
REQ-030 SHALL NOT expire or decrement when TMR_LOAD is written with 0.
REQ-031 SHALL clear EXP when a 1 is written to TMR_STATUS bit0; writing 0 has no effect.
REQ-032 SHALL keep EXP=1 when a clear and an expiry occur on the same edge, because set wins.
REQ-033 SHALL drive TMR_IRQ = EXP & IE as a pure combinational level, not a pulse.
REQ-034 SHALL NOT wrap COUNT below 0.

Reset
REQ-035 SHALL, while RESET=0, asynchronously force LEDS=0, SSEG=0, TMR_CTRL=0, the load register=0, COUNT=0, EXP=0, the synchronizer flops=0 and the FSM to STOPPED.
REQ-036 SHALL give TMR_IRQ=0 and an SW read of 0 during reset.
REQ-037 SHALL abandon any timer count in progress on reset mid-count.
REQ-038 SHALL resume normal operation on the first rising edge after RESET returns high.

Verification
REQ-039 SHALL be verified with: write 0x1100_0020 with data 0xDEAD_BEEF, WR=1 -> LEDS=0xBEEF next edge; read 0x1100_0020 -> IOBUS_IN=0x0000_BEEF.
REQ-040 SHALL be verified with: SWITCHES=0x0002 -> read 0x1100_0000 returns 0x0000_0002 after exactly 2 edges, 0 before.
REQ-041 SHALL be verified with: LOAD=3, CTRL=0x5 -> COUNT reads 3,2,1,0; EXP=1 and TMR_IRQ=1 at the edge COUNT becomes 0; COUNT stays 0 (HALTED).
REQ-042 SHALL be verified with: LOAD=2, CTRL=0x7 -> COUNT 2,1,2,1 and EXP set at each reload; W1C to 0x1100_006C on the expiry edge leaves EXP=1; W1C on a non-expiry edge clears it and drops TMR_IRQ.
REQ-043 SHALL be verified with: read 0x1100_0010 and write 0x1100_0070 -> IOBUS_IN=0, and no register changes.
REQ-044 SHALL be verified with: RESET low mid-count at COUNT=5 -> all outputs 0 immediately, without waiting for a clock edge; after RESET releases, COUNT=0 and the FSM is STOPPED.
